// File: rtl/tl_pkg.sv
// tl_pkg: shared state encoding, road indices and request decode helpers
package tl_pkg;
  typedef enum logic [1:0] {S_CLEAR, S_GREEN, S_YELLOW, S_FAULT} state_t;
  localparam logic [1:0] MR1 = 2'd0;
  localparam logic [1:0] MR2 = 2'd1;
  localparam logic [1:0] MR3 = 2'd2;
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction
  function automatic logic [1:0] oh3_to_idx(input logic [2:0] v);
    return v[2] ? MR3 : v[1] ? MR2 : MR1;
  endfunction
  function automatic logic [2:0] idx_to_oh3(input logic [1:0] i);
    return 3'b001 << i;
  endfunction
endpackage

// File: rtl/tl_interval_timer.sv
// tl_interval_timer: tick-enabled up counter that clears on demand and saturates at a terminal count
module tl_interval_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             at_term
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign at_term = cnt_q == term;
  // clear wins; otherwise count on enable until the terminal value is reached
  always_comb cnt_d = clr ? '0 : (en && !at_term) ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/tl_lamp_sequencer.sv
// tl_lamp_sequencer: turns per-road green requests into lamp drive with yellow, all-red and min-green; TL_FAULT_FLASH_EN selects flashing-yellow fault lamps
module tl_lamp_sequencer
  import tl_pkg::*;
#(
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int MIN_GREEN  = 4,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [2:0] req_g,
  input  logic       fault_clr,
  output logic [2:0] red_mr,
  output logic [2:0] yellow_mr,
  output logic [2:0] green_mr,
  output logic       fault,
  output logic       busy
);
  localparam logic [CNT_W-1:0] Y_T  = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] AR_T = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] MG_T = CNT_W'(MIN_GREEN - 1);
  state_t     state_q, state_d;
  logic [1:0] road_q, road_d;
  logic       met_q, met_d;
  logic [2:0] red_q, red_d, yel_q, yel_d, grn_q, grn_d;
  logic       fault_q, fault_d, busy_q, busy_d;
  logic       t_clr, at_term, done_tick, multi, one_hot;
  logic [CNT_W-1:0] t_term;
`ifdef TL_FAULT_FLASH_EN
  logic [2:0] pre_q, pre_d;
  logic       flash_q, flash_d;
`endif
  assign multi     = popcount3(req_g) > 2'd1;
  assign one_hot   = popcount3(req_g) == 2'd1;
  assign t_term    = state_q == S_GREEN ? MG_T : state_q == S_YELLOW ? Y_T : AR_T;
  assign done_tick = tick && at_term;
  tl_interval_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (t_clr),
    .en     (tick),
    .term   (t_term),
    .at_term(at_term)
  );
  // state, road, met and registered lamp outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLEAR;
      road_q  <= MR1;
      met_q   <= 1'b0;
      red_q   <= 3'b111;
      yel_q   <= 3'b000;
      grn_q   <= 3'b000;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef TL_FAULT_FLASH_EN
      pre_q   <= 3'd0;
      flash_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      road_q  <= road_d;
      met_q   <= met_d;
      red_q   <= red_d;
      yel_q   <= yel_d;
      grn_q   <= grn_d;
      fault_q <= fault_d;
      busy_q  <= busy_d;
`ifdef TL_FAULT_FLASH_EN
      pre_q   <= pre_d;
      flash_q <= flash_d;
`endif
    end
  end
  // next state: conflicts override everything; in CLEAR met remembers that clearance finished
  always_comb begin
    state_d = state_q;
    road_d  = road_q;
    met_d   = met_q;
    t_clr   = 1'b0;
    if (multi) begin
      state_d = S_FAULT;
      met_d   = 1'b0;
      t_clr   = 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          met_d = met_q || done_tick;
          if (met_d && one_hot) begin
            state_d = S_GREEN;
            road_d  = oh3_to_idx(req_g);
            met_d   = 1'b0;
            t_clr   = 1'b1;
          end
        end
        S_GREEN: begin
          met_d = met_q || done_tick;
          if (met_d && req_g != idx_to_oh3(road_q)) begin
            state_d = S_YELLOW;
            t_clr   = 1'b1;
          end
        end
        S_YELLOW: begin
          if (done_tick) begin
            state_d = S_CLEAR;
            met_d   = 1'b0;
            t_clr   = 1'b1;
          end
        end
        default: begin
          if (fault_clr) begin
            state_d = S_CLEAR;
            met_d   = 1'b0;
            t_clr   = 1'b1;
          end
        end
      endcase
    end
  end
  // lamp decode from the next state; busy only for CLEAR reached through YELLOW
  always_comb begin
    grn_d   = state_d == S_GREEN ? idx_to_oh3(road_d) : 3'b000;
    yel_d   = state_d == S_YELLOW ? idx_to_oh3(road_d) : 3'b000;
    red_d   = ~(grn_d | yel_d);
    fault_d = state_d == S_FAULT;
    busy_d  = state_d == S_YELLOW ||
              (state_d == S_CLEAR && (state_q == S_YELLOW || (state_q == S_CLEAR && busy_q)));
`ifdef TL_FAULT_FLASH_EN
    pre_d   = state_q != S_FAULT ? 3'd0 : tick ? pre_q + 3'd1 : pre_q;
    flash_d = state_q != S_FAULT ? 1'b1 : (tick && pre_q == 3'd7) ? ~flash_q : flash_q;
    red_d   = fault_d ? 3'b000 : red_d;
    yel_d   = fault_d ? {3{flash_d}} : yel_d;
`else
    red_d   = fault_d ? 3'b111 : red_d;
`endif
  end
  assign red_mr    = red_q;
  assign yellow_mr = yel_q;
  assign green_mr  = grn_q;
  assign fault     = fault_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_tl_lamp_sequencer.sv
// tb_tl_lamp_sequencer: directed scoreboard bench for the lamp sequencer
module tb_tl_lamp_sequencer;
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] y;
    logic [2:0] g;
    logic       f;
    logic       b;
  } obs_t;
`ifdef TL_FAULT_FLASH_EN
  localparam logic [2:0] FR = 3'b000;
  localparam logic [2:0] FY = 3'b111;
`else
  localparam logic [2:0] FR = 3'b111;
  localparam logic [2:0] FY = 3'b000;
`endif
  logic       clk = 1'b0;
  logic       reset, tick, fault_clr;
  logic [2:0] req_g, red_mr, yellow_mr, green_mr;
  logic       fault, busy;
  obs_t       sb[$];
  obs_t       obs, e;
  int         tests = 0;
  int         fails = 0;
  logic       div = 1'b0;
  int         tphase = 0;
  always #5 clk = ~clk;
  assign obs = {red_mr, yellow_mr, green_mr, fault, busy};
  tl_lamp_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .req_g    (req_g),
    .fault_clr(fault_clr),
    .red_mr   (red_mr),
    .yellow_mr(yellow_mr),
    .green_mr (green_mr),
    .fault    (fault),
    .busy     (busy)
  );
  task automatic steps(input logic [2:0] r, input logic [2:0] y, input logic [2:0] g,
                       input logic f, input logic b, input int n, input string tag);
    for (int i = 0; i < n; i++) sb.push_back({r, y, g, f, b});
    for (int i = 0; i < n; i++) begin
      tick   = div ? (tphase == 3) : 1'b1;
      tphase = (tphase + 1) % 4;
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s step %0d: got r=%b y=%b g=%b f=%b b=%b, want r=%b y=%b g=%b f=%b b=%b",
               tag, i, obs.r, obs.y, obs.g, obs.f, obs.b, e.r, e.y, e.g, e.f, e.b);
      end
    end
  endtask
  initial begin
    reset = 1'b1; req_g = 3'b001; tick = 1'b1; fault_clr = 1'b0;
    steps(3'b111, 3'b000, 3'b000, 0, 0, 2, "reset");
    reset = 1'b0;
    steps(3'b111, 3'b000, 3'b000, 0, 0, 1, "clear_after_reset");
    steps(3'b110, 3'b000, 3'b001, 0, 0, 1, "green_mr1");
    req_g = 3'b010;
    steps(3'b110, 3'b000, 3'b001, 0, 0, 3, "min_green_hold");
    steps(3'b110, 3'b001, 3'b000, 0, 1, 3, "yellow_mr1");
    steps(3'b111, 3'b000, 3'b000, 0, 1, 2, "allred_busy");
    steps(3'b101, 3'b000, 3'b010, 0, 0, 1, "green_mr2");
    req_g = 3'b100;
    steps(3'b101, 3'b000, 3'b010, 0, 0, 3, "hold_mr2");
    steps(3'b101, 3'b010, 3'b000, 0, 1, 1, "yellow_mr2");
    req_g = 3'b010;
    steps(3'b101, 3'b010, 3'b000, 0, 1, 2, "yellow_completes");
    steps(3'b111, 3'b000, 3'b000, 0, 1, 2, "clear_after_restore");
    steps(3'b101, 3'b000, 3'b010, 0, 0, 1, "green_mr2_again");
    div = 1'b1; tphase = 0; req_g = 3'b001;
    steps(3'b101, 3'b000, 3'b010, 0, 0, 15, "slow_green");
    steps(3'b101, 3'b010, 3'b000, 0, 1, 12, "slow_yellow");
    steps(3'b111, 3'b000, 3'b000, 0, 1, 8, "slow_clear");
    steps(3'b110, 3'b000, 3'b001, 0, 0, 1, "slow_green_mr1");
    steps(3'b110, 3'b000, 3'b001, 0, 0, 16, "slow_met");
    req_g = 3'b100;
    steps(3'b110, 3'b001, 3'b000, 0, 1, 1, "req_change_no_tick");
    div = 1'b0;
    steps(3'b110, 3'b001, 3'b000, 0, 1, 2, "yellow_tail");
    steps(3'b111, 3'b000, 3'b000, 0, 1, 2, "clear_tail");
    steps(3'b011, 3'b000, 3'b100, 0, 0, 1, "green_mr3");
    req_g = 3'b011;
    steps(FR, FY, 3'b000, 1, 0, 1, "fault_entry");
    fault_clr = 1'b1;
    steps(FR, FY, 3'b000, 1, 0, 1, "clr_blocked");
    req_g = 3'b100;
    steps(3'b111, 3'b000, 3'b000, 0, 0, 1, "fault_exit");
    fault_clr = 1'b0;
    steps(3'b111, 3'b000, 3'b000, 0, 0, 1, "clear_after_fault");
    steps(3'b011, 3'b000, 3'b100, 0, 0, 1, "green_after_fault");
    req_g = 3'b110;
`ifdef TL_FAULT_FLASH_EN
    steps(3'b000, 3'b111, 3'b000, 1, 0, 8, "flash_on");
    steps(3'b000, 3'b000, 3'b000, 1, 0, 8, "flash_off");
    steps(3'b000, 3'b111, 3'b000, 1, 0, 1, "flash_on_again");
`else
    steps(FR, FY, 3'b000, 1, 0, 3, "fault_hold");
`endif
    reset = 1'b1; req_g = 3'b101;
    steps(3'b111, 3'b000, 3'b000, 0, 0, 1, "reset_in_fault");
    reset = 1'b0; req_g = 3'b000;
    steps(3'b111, 3'b000, 3'b000, 0, 0, 4, "idle_clear");
    req_g = 3'b010;
    steps(3'b101, 3'b000, 3'b010, 0, 0, 1, "green_after_idle");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
